free_list: RTL and testbench

- Circular FIFO of free physical register indices. It is the consumer end of the retired-RAT free-list push interface.
- Rename/dispatch pops up to SS fresh pregs per cycle. Retirement pushes each stale preg back.
- Maintains a commit pointer so a pipeline flush reclaims every speculatively allocated preg in one cycle.

---
 rtl/free_list.sv | 136 +++++++++++++
 tb/tb_free_list.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Circular free list of physical register indices with speculative and committed
// read pointers. Define FREE_LIST_CHECK_EN to elaborate simulation-only sanity checks.

// Per-lane storage index generation: read lanes compact onto the head by pop_mask,
// write lanes compact onto the tail by push_en.
module free_list_lane #(
  parameter int IW    = 5,
  parameter int CNT_W = 2
) (
  input  logic [IW-1:0]    head_idx,
  input  logic [IW-1:0]    tail_idx,
  input  logic [CNT_W-1:0] pop_off,
  input  logic [CNT_W-1:0] push_off,
  output logic [IW-1:0]    rd_idx,
  output logic [IW-1:0]    wr_idx
);
  // DEPTH is a power of two, so truncation is the mod-DEPTH wrap.
  assign rd_idx = head_idx + IW'(pop_off);
  assign wr_idx = tail_idx + IW'(push_off);
endmodule

module free_list #(
  parameter int SS        = 2,
  parameter int NUM_PREGS = 64,
  parameter int DEPTH     = NUM_PREGS - 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SS-1:0]                        push_en,
  input  logic [SS-1:0][$clog2(NUM_PREGS)-1:0] push_entry,
  input  logic [SS-1:0]                        pop_mask,
  input  logic                                 pop_en,
  input  logic                                 flush,
  output logic [SS-1:0][$clog2(NUM_PREGS)-1:0] free_entry,
  output logic                                 pop_ready,
  output logic [$clog2(NUM_PREGS):0]           avail_cnt
);
  localparam int PW    = $clog2(NUM_PREGS);
  localparam int IW    = $clog2(DEPTH);
  localparam int PTR_W = IW + 1;
  localparam int CNT_W = $clog2(SS + 1);
  localparam int BASE  = NUM_PREGS - DEPTH;

  logic [PW-1:0]            entries [DEPTH];
  logic [PTR_W-1:0]         head, commit_head, tail;
  logic [PTR_W-1:0]         occ, commit_nxt;
  logic [SS:0][CNT_W-1:0]   pop_off, push_off;
  logic [CNT_W-1:0]         pop_n, push_n;
  logic [SS-1:0][IW-1:0]    rd_idx, wr_idx;
  logic                     pop_fire;

  // Exclusive prefix counts: lane i's offset is the number of active lanes below it.
  always_comb begin
    pop_off[0]  = '0;
    push_off[0] = '0;
    for (int i = 0; i < SS; i++) begin
      pop_off[i+1]  = pop_off[i]  + CNT_W'(pop_mask[i]);
      push_off[i+1] = push_off[i] + CNT_W'(push_en[i]);
    end
  end

  assign pop_n      = pop_off[SS];
  assign push_n     = push_off[SS];
  assign occ        = tail - head;
  assign avail_cnt  = (PW+1)'(occ);
  assign pop_ready  = PTR_W'(pop_n) <= occ;
  assign pop_fire   = pop_en && pop_ready && !flush;
  assign commit_nxt = commit_head + PTR_W'(push_n);

  for (genvar g = 0; g < SS; g++) begin : g_lane
    free_list_lane #(.IW(IW), .CNT_W(CNT_W)) u_lane (
      .head_idx (head[IW-1:0]),
      .tail_idx (tail[IW-1:0]),
      .pop_off  (pop_off[g]),
      .push_off (push_off[g]),
      .rd_idx   (rd_idx[g]),
      .wr_idx   (wr_idx[g])
    );
    assign free_entry[g] = pop_mask[g] ? entries[rd_idx[g]] : 'x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= PW'(BASE + i);
      head        <= '0;
      commit_head <= '0;
      tail        <= PTR_W'(DEPTH);
    end else begin
      for (int i = 0; i < SS; i++)
        if (push_en[i]) entries[wr_idx[i]] <= push_entry[i];
      tail        <= tail + PTR_W'(push_n);
      commit_head <= commit_nxt;
      // Flush rewinds to the post-retire commit point; pops that cycle are dropped.
      if (flush)         head <= commit_nxt;
      else if (pop_fire) head <= head + PTR_W'(pop_n);
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] in_list, in_list_nxt;
  logic [PTR_W-1:0]     spec_cnt;

  assign spec_cnt = head - commit_nxt;

  always_comb begin
    in_list_nxt = in_list;
    if (pop_fire)
      for (int i = 0; i < SS; i++)
        if (pop_mask[i]) in_list_nxt[entries[rd_idx[i]]] = 1'b0;
    for (int i = 0; i < SS; i++)
      if (push_en[i]) in_list_nxt[push_entry[i]] = 1'b1;
    // Speculatively handed-out pregs between the commit point and head come back.
    if (flush)
      for (int k = 0; k < DEPTH; k++)
        if (PTR_W'(k) < spec_cnt) in_list_nxt[entries[IW'(commit_nxt + PTR_W'(k))]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) in_list[i] <= (i >= BASE);
    end else begin
      in_list <= in_list_nxt;
      if ((PW+1)'(occ) + (PW+1)'(push_n) > (PW+1)'(DEPTH))
        $error("free_list: push overflows list");
      if (pop_en && !pop_ready && !flush)
        $error("free_list: pop while not ready");
      for (int i = 0; i < SS; i++)
        if (push_en[i] && in_list[push_entry[i]])
          $error("free_list: pushed preg %0d already free", push_entry[i]);
      if ((head - commit_head) > PTR_W'(DEPTH))
        $error("free_list: commit_head ahead of head");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: fixed vector table plus queue-based model
// scoreboard for the multi-cycle sequences and a long randomized run.
module tb_free_list;
  localparam int SS = 2, NP = 64, D = 32;

  logic                clk = 1'b0;
  logic                rst, pop_en, flush, pop_ready;
  logic [SS-1:0]       push_en, pop_mask;
  logic [SS-1:0][5:0]  push_entry, free_entry;
  logic [6:0]          avail_cnt;

  always #5 clk = ~clk;

  free_list #(.SS(SS), .NUM_PREGS(NP), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_entry(push_entry),
    .pop_mask(pop_mask), .pop_en(pop_en), .flush(flush),
    .free_entry(free_entry), .pop_ready(pop_ready), .avail_cnt(avail_cnt)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic pe, input logic [1:0] pu,
                       input int e0, input int e1, input logic fl);
    pop_mask = m; pop_en = pe; push_en = pu;
    push_entry[0] = 6'(e0); push_entry[1] = 6'(e1); flush = fl;
  endtask

  // ---------------- reference model ----------------
  // cq: list contents from the commit point onward; the first nspec are handed out.
  // pool: pregs not in the list (mapped), source of pushes in the random run.
  int cq[$], pool[$];
  int nspec;

  typedef struct {
    logic [1:0] m;
    bit v0, v1;
    int fe0, fe1, avail;
    bit ready;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_reset();
    cq.delete(); pool.delete(); nspec = 0;
    for (int i = 0; i < D; i++) cq.push_back(32 + i);
    for (int i = 0; i < 32; i++) pool.push_back(i);
  endfunction

  function automatic exp_t model_exp(input logic [1:0] m);
    exp_t e;
    int av, i1;
    av = cq.size() - nspec;
    i1 = nspec + int'(m[0]);
    e.m = m; e.avail = av;
    e.ready = (int'(m[0]) + int'(m[1])) <= av;
    e.v0 = m[0] && (nspec < cq.size());
    e.v1 = m[1] && (i1 < cq.size());
    e.fe0 = e.v0 ? cq[nspec] : 0;
    e.fe1 = e.v1 ? cq[i1] : 0;
    return e;
  endfunction

  function automatic void model_update(input logic [1:0] m, input logic pe, input logic [1:0] pu,
                                       input int e0, input int e1, input logic fl, input bit ready);
    int pn;
    if (pe && ready && !fl) nspec += int'(m[0]) + int'(m[1]);
    if (pu[0]) cq.push_back(e0);
    if (pu[1]) cq.push_back(e1);
    pn = int'(pu[0]) + int'(pu[1]);
    repeat (pn) begin
      pool.push_back(cq.pop_front());
      nspec--;
    end
    if (fl) nspec = 0;
  endfunction

  // One scoreboarded cycle: expectation queued at drive time, compared mid-cycle.
  task automatic sb_cycle(input string nm, input logic [1:0] m, input logic pe, input logic [1:0] pu,
                          input int e0, input int e1, input logic fl);
    exp_t e;
    drive(m, pe, pu, e0, e1, fl);
    sbq.push_back(model_exp(m));
    @(negedge clk);
    e = sbq.pop_front();
    chk({nm, " avail"}, 32'(avail_cnt), 32'(e.avail));
    chk({nm, " ready"}, 32'(pop_ready), 32'(e.ready));
    if (e.v0) chk({nm, " fe0"}, 32'(free_entry[0]), 32'(e.fe0));
    if (e.v1) chk({nm, " fe1"}, 32'(free_entry[1]), 32'(e.fe1));
    model_update(m, pe, pu, e0, e1, fl, e.ready);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // ---------------- fixed vector table ----------------
  typedef struct {
    logic [1:0] m; logic pe; logic [1:0] pu; int e0, e1; logic fl;
    int fe0, fe1, avail; logic ready;
  } vec_t;
  vec_t vt[8];

  initial begin
    // Hand-derived from reset: entries[i]=32+i, head=0, tail=32.
    vt[0] = '{2'b11, 1, 2'b00, 0, 0, 0, 32, 33, 32, 1};
    vt[1] = '{2'b11, 1, 2'b00, 0, 0, 0, 34, 35, 30, 1};
    vt[2] = '{2'b10, 1, 2'b00, 0, 0, 0,  0, 36, 28, 1};
    vt[3] = '{2'b01, 0, 2'b00, 0, 0, 0, 37,  0, 27, 1};
    vt[4] = '{2'b00, 1, 2'b00, 0, 0, 0,  0,  0, 27, 1};
    vt[5] = '{2'b01, 1, 2'b01, 7, 0, 0, 37,  0, 27, 1};
    vt[6] = '{2'b11, 1, 2'b00, 0, 0, 1, 38, 39, 27, 1};   // flush: pop dropped
    vt[7] = '{2'b11, 0, 2'b00, 0, 0, 0, 33, 34, 32, 1};   // head rewound to commit

    rst = 1'b0;
    drive(2'b00, 1'b0, 2'b00, 0, 0, 1'b0);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("reset avail", 32'(avail_cnt), 32);
    chk("reset ready", 32'(pop_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].m, vt[i].pe, vt[i].pu, vt[i].e0, vt[i].e1, vt[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d avail", i), 32'(avail_cnt), 32'(vt[i].avail));
      chk($sformatf("vec%0d ready", i), 32'(pop_ready), 32'(vt[i].ready));
      if (vt[i].m[0]) chk($sformatf("vec%0d fe0", i), 32'(free_entry[0]), 32'(vt[i].fe0));
      if (vt[i].m[1]) chk($sformatf("vec%0d fe1", i), 32'(free_entry[1]), 32'(vt[i].fe1));
      @(posedge clk); #1;
    end

    // After flush, drain order continues 33..63 then the retired 7 in slot 0.
    for (int i = 0; i < 15; i++) sb_cycle_tbl_skip();
    drive(2'b11, 1'b0, 2'b00, 0, 0, 1'b0);
    @(negedge clk);
    chk("flush drain fe0", 32'(free_entry[0]), 63);
    chk("flush drain fe1", 32'(free_entry[1]), 7);
    chk("flush drain avail", 32'(avail_cnt), 2);
    @(posedge clk); #1;

    // Empty list: drain 32, then a single pop must stall until a push lands.
    do_reset();
    for (int i = 0; i < 16; i++) sb_cycle("drain", 2'b11, 1, 2'b00, 0, 0, 0);
    drive(2'b01, 1'b0, 2'b00, 0, 0, 1'b0);
    @(negedge clk);
    chk("empty avail", 32'(avail_cnt), 0);
    chk("empty ready m01", 32'(pop_ready), 0);
    pop_mask = 2'b00;
    #1 chk("empty ready m00", 32'(pop_ready), 1);
    @(posedge clk); #1;
    sb_cycle("stall", 2'b01, 1, 2'b00, 0, 0, 0);
    sb_cycle("push5", 2'b01, 1, 2'b01, 5, 0, 0);   // not bypassed: still empty this cycle
    drive(2'b01, 1'b0, 2'b00, 0, 0, 1'b0);
    @(negedge clk);
    chk("refill fe0", 32'(free_entry[0]), 5);
    chk("refill ready", 32'(pop_ready), 1);
    @(posedge clk); #1;

    // Simultaneous push and pop keeps the count steady.
    do_reset();
    sb_cycle("pp0", 2'b11, 1, 2'b00, 0, 0, 0);
    sb_cycle("pp1", 2'b11, 1, 2'b11, 9, 10, 0);
    @(negedge clk);
    chk("pushpop avail", 32'(avail_cnt), 30);
    @(posedge clk); #1;

    // Long randomized run: pushes only commit outstanding allocations, so tail wraps repeatedly.
    do_reset();
    for (int c = 0; c < 160; c++) begin
      logic [1:0] m, pu;
      logic pe, fl;
      int e0, e1, want;
      m  = ($urandom_range(0, 9) < 8) ? 2'b11 : 2'($urandom_range(0, 3));
      pe = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 29) == 0);
      want = (nspec >= 2) ? $urandom_range(1, 2) : nspec;
      if ($urandom_range(0, 4) == 0) want = 0;
      pu = (want == 2) ? 2'b11 : (want == 1) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) : 2'b00;
      e0 = pu[0] ? pool.pop_front() : 0;
      e1 = pu[1] ? pool.pop_front() : 0;
      sb_cycle($sformatf("rnd%0d", c), m, pe, pu, e0, e1, fl);
    end
    // Final drain checks every preg still in the list, in order.
    sb_cycle("rnd flush", 2'b00, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 16; i++) sb_cycle("rnd drain", 2'b11, 1, 2'b00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Continues the post-flush drain of the table sequence through the model-free path.
  int drain_next = 33;
  task automatic sb_cycle_tbl_skip();
    drive(2'b11, 1'b1, 2'b00, 0, 0, 1'b0);
    @(negedge clk);
    chk("flush seq fe0", 32'(free_entry[0]), 32'(drain_next));
    chk("flush seq fe1", 32'(free_entry[1]), 32'(drain_next + 1));
    drain_next += 2;
    @(posedge clk); #1;
  endtask

endmodule
